// File: rtl/i2cm_pad_filter.sv
// Pad conditioning ahead of the I2C master core: 2-flop synchronisers, programmable glitch
// filter, SCL edge / START / STOP decode and bus-busy tracking.
// Optional stuck-bus detector is built only when I2CM_PAD_STUCK_DET_EN is defined.
module i2cm_pad_filter #(
  parameter int FILT_WIDTH  = 4,
  parameter int STUCK_WIDTH = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   en,
  input  logic [FILT_WIDTH-1:0]  filt_len,
  input  logic                   pad_scl_in,
  input  logic                   pad_sda_in,
  output logic                   io_scl_in,
  output logic                   io_sda_in,
  output logic                   scl_rise,
  output logic                   scl_fall,
  output logic                   start_det,
  output logic                   stop_det,
  output logic                   bus_busy,
  input  logic [STUCK_WIDTH-1:0] stuck_lim,
  input  logic                   stuck_clr,
  output logic                   bus_stuck
);

  logic                  r_scl_s1, r_scl_s2;
  logic                  r_sda_s1, r_sda_s2;
  logic                  r_f_scl, r_f_sda;
  logic                  r_f_scl_d, r_f_sda_d;
  logic [FILT_WIDTH-1:0] r_cnt_scl, r_cnt_sda;
  logic                  r_busy;
  logic                  w_start;
  logic                  w_stop;

  // Synchronisers keep sampling even while disabled so re-enable sees current pad state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= pad_scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= pad_sda_in;
      r_sda_s2 <= r_sda_s1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_f_scl   <= 1'b1;
      r_cnt_scl <= '0;
    end else if (!en) begin
      r_f_scl   <= 1'b1;
      r_cnt_scl <= '0;
    end else if (r_scl_s2 == r_f_scl) begin
      r_cnt_scl <= '0;
    end else if (r_cnt_scl >= filt_len) begin
      r_f_scl   <= r_scl_s2;
      r_cnt_scl <= '0;
    end else begin
      r_cnt_scl <= r_cnt_scl + FILT_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_f_sda   <= 1'b1;
      r_cnt_sda <= '0;
    end else if (!en) begin
      r_f_sda   <= 1'b1;
      r_cnt_sda <= '0;
    end else if (r_sda_s2 == r_f_sda) begin
      r_cnt_sda <= '0;
    end else if (r_cnt_sda >= filt_len) begin
      r_f_sda   <= r_sda_s2;
      r_cnt_sda <= '0;
    end else begin
      r_cnt_sda <= r_cnt_sda + FILT_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_f_scl_d <= 1'b1;
      r_f_sda_d <= 1'b1;
    end else if (!en) begin
      r_f_scl_d <= 1'b1;
      r_f_sda_d <= 1'b1;
    end else begin
      r_f_scl_d <= r_f_scl;
      r_f_sda_d <= r_f_sda;
    end
  end

  // SCL must be high in both cycles, so a simultaneous SCL/SDA change is never START/STOP.
  assign w_start = en & r_f_scl & r_f_scl_d & r_f_sda_d & ~r_f_sda;
  assign w_stop  = en & r_f_scl & r_f_scl_d & ~r_f_sda_d & r_f_sda;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_busy <= 1'b0;
    end else if (!en) begin
      r_busy <= 1'b0;
    end else if (w_start) begin
      r_busy <= 1'b1;
    end else if (w_stop) begin
      r_busy <= 1'b0;
    end
  end

  assign io_scl_in = r_f_scl;
  assign io_sda_in = r_f_sda;
  assign scl_rise  = en & r_f_scl & ~r_f_scl_d;
  assign scl_fall  = en & ~r_f_scl & r_f_scl_d;
  assign start_det = w_start;
  assign stop_det  = w_stop;
  assign bus_busy  = r_busy;

`ifdef I2CM_PAD_STUCK_DET_EN
  logic [STUCK_WIDTH-1:0] r_stuck_cnt;
  logic                   r_stuck;

  // Set wins over clear; the low-time counter saturates rather than wrapping.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stuck_cnt <= '0;
      r_stuck     <= 1'b0;
    end else if (!en) begin
      r_stuck_cnt <= '0;
      r_stuck     <= 1'b0;
    end else begin
      if ((stuck_lim != '0) && (r_stuck_cnt == stuck_lim)) begin
        r_stuck <= 1'b1;
      end else if (stuck_clr) begin
        r_stuck <= 1'b0;
      end
      if (r_f_scl & r_f_sda) begin
        r_stuck_cnt <= '0;
      end else if (r_stuck_cnt != '1) begin
        r_stuck_cnt <= r_stuck_cnt + STUCK_WIDTH'(1);
      end
    end
  end

  assign bus_stuck = r_stuck;
`else
  logic w_unused_stuck;
  assign w_unused_stuck = ^{stuck_lim, stuck_clr};
  assign bus_stuck      = 1'b0;
`endif

endmodule

// File: tb/tb_i2cm_pad_filter.sv
// Bench for i2cm_pad_filter: directed bus scenarios plus randomized pad activity, all checked
// every cycle against a behavioural model of the filtered lines and bus events.
module tb_i2cm_pad_filter;
  localparam int FW = 4;
  localparam int SW = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          en;
  logic [FW-1:0] filt_len;
  logic          pad_scl_in, pad_sda_in;
  logic          io_scl_in, io_sda_in;
  logic          scl_rise, scl_fall, start_det, stop_det, bus_busy;
  logic [SW-1:0] stuck_lim;
  logic          stuck_clr;
  logic          bus_stuck;

  always #5 sys_clk = ~sys_clk;

  i2cm_pad_filter #(.FILT_WIDTH(FW), .STUCK_WIDTH(SW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .filt_len   (filt_len),
    .pad_scl_in (pad_scl_in),
    .pad_sda_in (pad_sda_in),
    .io_scl_in  (io_scl_in),
    .io_sda_in  (io_sda_in),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .bus_busy   (bus_busy),
    .stuck_lim  (stuck_lim),
    .stuck_clr  (stuck_clr),
    .bus_stuck  (bus_stuck)
  );

  int checks = 0;
  int errors = 0;
  int n_rise, n_fall, n_start, n_stop;

  // Model: pad history gives the synchronised value two samples late; a line's filtered value
  // follows it after filt_len+1 consecutive disagreeing samples.
  bit m_q_scl[$];
  bit m_q_sda[$];
  bit m_f_scl, m_f_sda;
  bit m_p_scl, m_p_sda;
  int m_run_scl, m_run_sda;
  bit m_busy;
  int m_low;
  bit m_stuck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q_scl = '{1'b1, 1'b1};
    m_q_sda = '{1'b1, 1'b1};
    m_f_scl = 1'b1; m_f_sda = 1'b1;
    m_p_scl = 1'b1; m_p_sda = 1'b1;
    m_run_scl = 0; m_run_sda = 0;
    m_busy = 1'b0; m_low = 0; m_stuck = 1'b0;
  endtask

  task automatic filt_line(input bit s, inout bit f, inout int run);
    if (s == f) begin
      run = 0;
    end else begin
      run++;
      if (run > int'(filt_len)) begin
        f = s;
        run = 0;
      end
    end
  endtask

  task automatic model_edge();
    bit st, sp, s_scl, s_sda, o_scl, o_sda;
    st = en && m_f_scl && m_p_scl && m_p_sda && !m_f_sda;
    sp = en && m_f_scl && m_p_scl && !m_p_sda && m_f_sda;
    if (!en) m_busy = 1'b0;
    else if (st) m_busy = 1'b1;
    else if (sp) m_busy = 1'b0;
    if (!en) begin
      m_low = 0;
      m_stuck = 1'b0;
    end else begin
      if (stuck_lim != 0 && m_low == int'(stuck_lim)) m_stuck = 1'b1;
      else if (stuck_clr) m_stuck = 1'b0;
      if (m_f_scl && m_f_sda) m_low = 0;
      else if (m_low < 65535) m_low++;
    end
    s_scl = m_q_scl.pop_front(); m_q_scl.push_back(pad_scl_in);
    s_sda = m_q_sda.pop_front(); m_q_sda.push_back(pad_sda_in);
    o_scl = m_f_scl;
    o_sda = m_f_sda;
    if (!en) begin
      m_f_scl = 1'b1; m_f_sda = 1'b1;
      m_run_scl = 0;  m_run_sda = 0;
    end else begin
      filt_line(s_scl, m_f_scl, m_run_scl);
      filt_line(s_sda, m_f_sda, m_run_sda);
    end
    m_p_scl = en ? o_scl : 1'b1;
    m_p_sda = en ? o_sda : 1'b1;
  endtask

  task automatic compare_all();
    bit e_stuck;
`ifdef I2CM_PAD_STUCK_DET_EN
    e_stuck = m_stuck;
`else
    e_stuck = 1'b0;
`endif
    chk("io_scl_in", io_scl_in, m_f_scl);
    chk("io_sda_in", io_sda_in, m_f_sda);
    chk("scl_rise",  scl_rise,  en & m_f_scl & ~m_p_scl);
    chk("scl_fall",  scl_fall,  en & ~m_f_scl & m_p_scl);
    chk("start_det", start_det, en & m_f_scl & m_p_scl & m_p_sda & ~m_f_sda);
    chk("stop_det",  stop_det,  en & m_f_scl & m_p_scl & ~m_p_sda & m_f_sda);
    chk("bus_busy",  bus_busy,  m_busy);
    chk("bus_stuck", bus_stuck, e_stuck);
    n_rise  += int'(scl_rise);
    n_fall  += int'(scl_fall);
    n_start += int'(start_det);
    n_stop  += int'(stop_det);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic clr_counts();
    n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0;
  endtask

  initial begin
    int z, first;
    sys_rst = 1'b1; en = 1'b1; filt_len = '0;
    pad_scl_in = 1'b1; pad_sda_in = 1'b1;
    stuck_lim = '0; stuck_clr = 1'b0;
    clr_counts();
    model_reset();
    repeat (2) @(negedge sys_clk);
    chk("rst_io_scl", io_scl_in, 1'b1);
    chk("rst_io_sda", io_sda_in, 1'b1);
    chk("rst_pulses", {scl_rise, scl_fall, start_det, stop_det}, 4'b0);
    chk("rst_busy", bus_busy, 1'b0);
    chk("rst_stuck", bus_stuck, 1'b0);
    sys_rst = 1'b0;

    // 1: SDA drop with filt_len 0 reaches io_sda_in three samples later as a START
    repeat (10) tick();
    clr_counts();
    pad_sda_in = 1'b0;
    tick(); tick();
    chk("t1_sda_hold", io_sda_in, 1'b1);
    tick();
    chk("t1_sda_fall", io_sda_in, 1'b0);
    chk("t1_start", start_det, 1'b1);
    tick();
    chk("t1_busy", bus_busy, 1'b1);
    chk("t1_other_pulses", n_rise + n_fall + n_stop, 0);
    chk("t1_start_cnt", n_start, 1);

    // 3: nine clock pulses, then STOP
    clr_counts();
    for (int p = 0; p < 9; p++) begin
      pad_scl_in = 1'b0; repeat (4) tick();
      pad_scl_in = 1'b1; repeat (4) tick();
    end
    pad_sda_in = 1'b1;
    repeat (5) tick();
    chk("t3_rise_cnt", n_rise, 9);
    chk("t3_fall_cnt", n_fall, 9);
    chk("t3_stop_cnt", n_stop, 1);
    chk("t3_start_cnt", n_start, 0);
    chk("t3_busy", bus_busy, 1'b0);

    // 2: filt_len 3 -- 3-sample glitch suppressed, 4-sample glitch passes 6 samples late
    filt_len = 4'd3;
    repeat (4) tick();
    pad_scl_in = 1'b0;
    z = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 4) pad_scl_in = 1'b1;
      tick();
      if (!io_scl_in) z++;
    end
    chk("t2_short_glitch", z, 0);
    pad_scl_in = 1'b0;
    z = 0; first = -1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) pad_scl_in = 1'b1;
      tick();
      if (!io_scl_in) begin
        z++;
        if (first < 0) first = i;
      end
    end
    chk("t2_long_delay", first, 6);
    chk("t2_long_width", z, 4);

    // 4: simultaneous SCL/SDA fall is an SCL edge only
    filt_len = '0;
    repeat (4) tick();
    clr_counts();
    pad_scl_in = 1'b0; pad_sda_in = 1'b0;
    repeat (6) tick();
    chk("t4_start_cnt", n_start, 0);
    chk("t4_fall_cnt", n_fall, 1);
    pad_scl_in = 1'b1; repeat (5) tick();
    pad_sda_in = 1'b1; repeat (5) tick();

    // 5: disable mid-transfer, then async reset mid-filter-count
    pad_sda_in = 1'b0; repeat (4) tick();
    pad_scl_in = 1'b0; repeat (4) tick();
    chk("t5_busy_before", bus_busy, 1'b1);
    en = 1'b0;
    tick();
    chk("t5_dis_scl", io_scl_in, 1'b1);
    chk("t5_dis_sda", io_sda_in, 1'b1);
    chk("t5_dis_busy", bus_busy, 1'b0);
    pad_scl_in = 1'b1; pad_sda_in = 1'b1;
    repeat (4) tick();
    en = 1'b1;
    repeat (4) tick();
    filt_len = 4'd5;
    pad_scl_in = 1'b0;
    repeat (8) tick();
    pad_scl_in = 1'b1; pad_sda_in = 1'b0;
    repeat (5) tick();
    sys_rst = 1'b1;
    #1;
    chk("t5_rst_scl", io_scl_in, 1'b1);
    chk("t5_rst_sda", io_sda_in, 1'b1);
    chk("t5_rst_pulses", {scl_rise, scl_fall, start_det, stop_det}, 4'b0);
    chk("t5_rst_busy", bus_busy, 1'b0);
    model_reset();
    pad_sda_in = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) tick();

    // 6: stuck-bus detection on a held-low SDA
    filt_len = '0;
    stuck_lim = 16'd20;
    pad_sda_in = 1'b0;
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus_stuck && first < 0) first = i;
    end
`ifdef I2CM_PAD_STUCK_DET_EN
    chk("t6_stuck_time", first, 24);
`else
    chk("t6_stuck_time", first, -1);
`endif
    pad_sda_in = 1'b1;
    repeat (5) tick();
`ifdef I2CM_PAD_STUCK_DET_EN
    chk("t6_stuck_sticky", bus_stuck, 1'b1);
`else
    chk("t6_stuck_sticky", bus_stuck, 1'b0);
`endif
    stuck_clr = 1'b1;
    tick();
    stuck_clr = 1'b0;
    chk("t6_stuck_clr", bus_stuck, 1'b0);
    stuck_lim = '0;
    repeat (3) tick();

    // Randomized pad activity with varying filter length, enable drops and stuck settings
    for (int ph = 0; ph < 6; ph++) begin
      filt_len  = FW'($urandom_range(0, 4));
      stuck_lim = SW'($urandom_range(0, 12));
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 3) == 0) pad_scl_in = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) pad_sda_in = 1'($urandom_range(0, 1));
        en        = ($urandom_range(0, 40) != 0);
        stuck_clr = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    en = 1'b1; stuck_clr = 1'b0;
    pad_scl_in = 1'b1; pad_sda_in = 1'b1;
    repeat (12) tick();
    chk("end_idle_scl", io_scl_in, 1'b1);
    chk("end_idle_sda", io_sda_in, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
